seg7_scan_sched: RTL and testbench



---
 rtl/seg7_scan_sched.sv | 112 +++++++++++
 tb/tb_seg7_scan_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_sched.sv
// Time-multiplexed scan scheduler for a 4-digit 7-segment display.
// Snapshots digits once per frame, adds a dark guard interval per slot, leading-zero suppression and brightness PWM.
module seg7_scan_sched #(
   parameter int PRESCALE    = 50000,
   parameter int GUARD       = 16,
   parameter bit SEL_ACT_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        lz_suppress,
   input  logic [3:0]  bright,
   output logic [3:0]  hex_out,
   output logic        dp_out,
   output logic [3:0]  sel,
   output logic        seg_blank,
   output logic        frame_start
);

   localparam int          TW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [TW-1:0] T_LAST  = TW'(PRESCALE - 1);
   localparam logic [TW-1:0] T_GUARD = TW'(GUARD);
   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic [3:0]  SEL_OFF = SEL_ACT_LOW ? 4'b1111 : 4'b0000;

   logic [1:0]    s;
   logic [TW-1:0] t;
   logic [3:0]    p;
   logic [15:0]   sh_digits;
   logic [3:0]    sh_dp;
   logic [3:0]    sh_blank;

   logic          snap;
   logic          on;
   logic          lit;
   logic [15:0]   cur_digits;
   logic [3:0]    cur_dp;
   logic [3:0]    cur_blank;
   logic [3:0]    cur_hex;
   logic [3:0]    p_eff;
   logic [3:0]    supp;
   logic [3:0]    onehot;

   // The snapshot cycle already displays the freshly captured values.
   assign snap       = (s == 2'd0) && (t == '0);
   assign cur_digits = snap ? digits_in : sh_digits;
   assign cur_dp     = snap ? dp_in     : sh_dp;
   assign cur_blank  = snap ? blank_in  : sh_blank;
   assign cur_hex    = cur_digits[{s, 2'b00} +: 4];

   generate
      if (GUARD == 0) begin : g_no_guard
         assign on = 1'b1;
      end else begin : g_guard
         assign on = (t >= T_GUARD);
      end
   endgenerate

   // PWM phase restarts at the first ON cycle of every slot.
   assign p_eff  = (t == T_GUARD) ? 4'd0 : p;
   assign onehot = 4'b0001 << s;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      supp    = 4'b0000;
      supp[3] = lz_suppress && (cur_digits[15:12] == 4'h0);
      supp[2] = supp[3]     && (cur_digits[11:8]  == 4'h0);
      supp[1] = supp[2]     && (cur_digits[7:4]   == 4'h0);
   end

   assign lit = on && !cur_blank[s] && !supp[s] && (p_eff <= bright);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (RESET) begin
         s           <= 2'd0;
         t           <= '0;
         p           <= 4'd0;
         sh_digits   <= 16'h0000;
         sh_dp       <= 4'b0000;
         sh_blank    <= 4'b0000;
         hex_out     <= 4'h0;
         dp_out      <= 1'b0;
         sel         <= SEL_OFF;
         seg_blank   <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         if (t == T_LAST) begin
            t <= '0;
            s <= s + 2'd1;
         end else begin
            t <= t + T_ONE;
         end
         if (on) begin
            p <= p_eff + 4'd1;
         end
         if (snap) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_blank  <= blank_in;
         end
         hex_out     <= cur_hex;
         dp_out      <= lit && cur_dp[s];
         sel         <= lit ? (onehot ^ SEL_OFF) : SEL_OFF;
         seg_blank   <= !lit;
         frame_start <= snap;
      end
   end

endmodule

// File: tb/tb_seg7_scan_sched.sv
// Bench for seg7_scan_sched: two configurations checked every cycle against an arithmetic frame/slot model.
module tb_seg7_scan_sched;

   localparam int PA = 8;
   localparam int GA = 2;
   localparam int PB = 40;
   localparam int GB = 4;

   logic        clk = 1'b0;
   logic        RESET;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lz_suppress;
   logic [3:0]  bright;

   logic [3:0]  hex_a, sel_a, hex_b, sel_b;
   logic        dp_a, blank_a, fs_a, dp_b, blank_b, fs_b;

   int total = 0;
   int bad   = 0;

   // Model state per configuration (0 = A, 1 = B).
   int          n   [2];
   logic [15:0] md  [2];
   logic [3:0]  mdp [2];
   logic [3:0]  mb  [2];
   logic [3:0]  e_hex [2];
   logic [3:0]  e_sel [2];
   logic        e_dp  [2];
   logic        e_blk [2];
   logic        e_fs  [2];

   always #5 clk = ~clk;

   seg7_scan_sched #(.PRESCALE(PA), .GUARD(GA), .SEL_ACT_LOW(1'b1)) dut_a (
      .clk(clk), .RESET(RESET), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
      .lz_suppress(lz_suppress), .bright(bright), .hex_out(hex_a), .dp_out(dp_a),
      .sel(sel_a), .seg_blank(blank_a), .frame_start(fs_a)
   );

   seg7_scan_sched #(.PRESCALE(PB), .GUARD(GB), .SEL_ACT_LOW(1'b0)) dut_b (
      .clk(clk), .RESET(RESET), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
      .lz_suppress(lz_suppress), .bright(bright), .hex_out(hex_b), .dp_out(dp_b),
      .sel(sel_b), .seg_blank(blank_b), .frame_start(fs_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected registered outputs for the cycle about to be clocked, from frame/slot arithmetic.
   task automatic model(input int c);
      int  pr, g, s, t;
      bit  act_low, supp, lit;
      logic [3:0] off;
      pr      = (c == 0) ? PA : PB;
      g       = (c == 0) ? GA : GB;
      act_low = (c == 0);
      off     = act_low ? 4'hF : 4'h0;
      if (RESET) begin
         n[c] = 0; md[c] = 16'h0; mdp[c] = 4'h0; mb[c] = 4'h0;
         e_hex[c] = 4'h0; e_dp[c] = 1'b0; e_sel[c] = off; e_blk[c] = 1'b1; e_fs[c] = 1'b0;
      end else begin
         s = (n[c] / pr) % 4;
         t = n[c] % pr;
         e_fs[c] = (n[c] % (4 * pr) == 0);
         if (e_fs[c]) begin
            md[c] = digits_in; mdp[c] = dp_in; mb[c] = blank_in;
         end
         supp = lz_suppress && (s > 0) && ((md[c] >> (4 * s)) == 16'h0);
         lit  = (t >= g) && !mb[c][s] && !supp && (((t - g) % 16) <= int'(bright));
         e_hex[c] = 4'((md[c] >> (4 * s)) & 16'hF);
         e_dp[c]  = lit && mdp[c][s];
         e_sel[c] = lit ? (act_low ? ~(4'b0001 << s) : (4'b0001 << s)) : off;
         e_blk[c] = !lit;
         n[c]++;
      end
   endtask

   task automatic step();
      model(0);
      model(1);
      @(posedge clk);
      #1;
      check("a_hex",   32'(hex_a),   32'(e_hex[0]));
      check("a_sel",   32'(sel_a),   32'(e_sel[0]));
      check("a_dp",    32'(dp_a),    32'(e_dp[0]));
      check("a_blank", 32'(blank_a), 32'(e_blk[0]));
      check("a_fs",    32'(fs_a),    32'(e_fs[0]));
      check("b_hex",   32'(hex_b),   32'(e_hex[1]));
      check("b_sel",   32'(sel_b),   32'(e_sel[1]));
      check("b_dp",    32'(dp_b),    32'(e_dp[1]));
      check("b_blank", 32'(blank_b), 32'(e_blk[1]));
      check("b_fs",    32'(fs_b),    32'(e_fs[1]));
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      int cnt;
      RESET = 1'b1; digits_in = 16'h1234; dp_in = 4'b0010; blank_in = 4'b0000;
      lz_suppress = 1'b0; bright = 4'd15;
      n[0] = 0; n[1] = 0;
      run(3);
      check("reset_sel_a", 32'(sel_a), 32'hF);
      check("reset_sel_b", 32'(sel_b), 32'h0);

      // Scan order, with frame_start counted over two A frames.
      RESET = 1'b0;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (fs_a) cnt++;
      end
      check("fs_per_64", 32'(cnt), 32'd2);

      // Tear-free update: change inputs once A is in slot 2.
      for (int i = 0; i < 64 && (n[0] % 32) != 16; i++) step();
      check("reach_slot2", 32'(n[0] % 32), 32'd16);
      digits_in = 16'hABCD;
      run(48);

      // Leading-zero suppression.
      digits_in = 16'h0040; lz_suppress = 1'b1;
      run(64);
      digits_in = 16'h0000;
      run(64);
      lz_suppress = 1'b0;
      run(64);

      // Brightness on the long-slot instance: 3 groups of 4 lit cycles per slot.
      digits_in = 16'h5678; bright = 4'd3;
      RESET = 1'b1; step(); RESET = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4 * PB; i++) begin
         step();
         if (!blank_b) cnt++;
      end
      check("bright3_lit", 32'(cnt), 32'd48);
      bright = 4'd0;
      cnt = 0;
      for (int i = 0; i < 4 * PB; i++) begin
         step();
         if (!blank_b) cnt++;
      end
      check("bright0_lit", 32'(cnt), 32'd12);

      // Blank mask, then reset in the middle of slot 2.
      bright = 4'd15; blank_in = 4'b0100;
      run(64);
      for (int i = 0; i < 64 && (n[0] % 32) != 18; i++) step();
      RESET = 1'b1; step(); RESET = 1'b0;
      check("midreset_blank", 32'(blank_a), 32'd1);
      run(40);

      // Randomized inputs with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) digits_in = 16'($urandom);
         if ($urandom_range(0, 29) == 0) digits_in = 16'($urandom_range(0, 255));
         if ($urandom_range(0, 39) == 0) dp_in = 4'($urandom);
         if ($urandom_range(0, 39) == 0) blank_in = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 49) == 0) lz_suppress = 1'($urandom);
         if ($urandom_range(0, 19) == 0) bright = 4'($urandom);
         RESET = ($urandom_range(0, 599) == 0);
         step();
      end
      RESET = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
